param_shift_register: RTL
=========================

Name: param_shift_register

Overview:
Parametrised universal storage register, WIDTH bits, driven by an op/amount command.
- Covers hold, parallel load, clear, logical/arithmetic shifts and rotates, with multi-bit shifts executed one bit per clock.
- Serial-in, busy/done handshake.
- Sits between switch/button front-ends and display/LED logic in lab top levels; replaces ad-hoc single-bit D-FF chains.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- RESET_VAL, 0, value loaded into q on reset (WIDTH bits).
- AMT_W (localparam), $clog2(WIDTH)+1, width of the shift-amount field.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; sampled only when busy=0.
- op  in  3  command opcode (see package).
- amt  in  AMT_W  number of single-bit steps for shift/rotate ops.
- d  in  WIDTH  parallel load data.
- si  in  1  serial input bit, sampled on every shift step.
- q  out  WIDTH  register contents (registered).
- busy  out  1  high while a multi-step shift is in progress.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port reset.
- Reset, async, effective immediately mid-operation: q=RESET_VAL, busy=0, done=0, state=IDLE, step counter=0.
- Opcodes: 0 HOLD, 1 LOAD, 2 CLR, 3 SHL, 4 SHR, 5 ASR, 6 ROL, 7 ROR.
- FSM states: IDLE, SHIFT.
- IDLE, start=1, op in {HOLD, LOAD, CLR}:
  - At edge E0: HOLD leaves q unchanged, LOAD sets q=d, CLR sets q=0.
  - done=1 for the cycle after E0.
  - busy stays 0; state stays IDLE.
- IDLE, start=1, shift/rotate op, amt=0: q unchanged, done pulses after E0, busy stays 0.
- IDLE, start=1, shift/rotate op, amt>0:
  - At E0, latch op, load cnt=amt, busy=1, go to SHIFT. No data change at E0.
- SHIFT, each edge: apply one step, cnt=cnt-1. At the edge where cnt goes 1->0: busy=0, done=1 (one cycle), state=IDLE.
  - busy is high for exactly amt cycles; final q is visible after edge E(amt).
- Step rules:
  - SHL: q={q[WIDTH-2:0],si}.
  - SHR: q={si,q[WIDTH-1:1]}.
  - ASR: q={q[WIDTH-1],q[WIDTH-1:1]}.
  - ROL: q={q[WIDTH-2:0],q[WIDTH-1]}.
  - ROR: q={q[0],q[WIDTH-1:1]}.
  - si is ignored by ASR and the rotates.
- amt is not clamped: exactly amt steps are performed. amt>=WIDTH on SHL/SHR fills q entirely with the si stream; on rotates it wraps.
- start while busy=1: ignored entirely (no queueing). op, amt and d are sampled only at acceptance; si is sampled live each step.
- done and start in the same cycle while in IDLE: the new command is accepted normally.
- done is never high in two consecutive cycles unless back-to-back single-cycle commands are issued.

Optional Feature:
USR_PARITY_EN
- Defined: adds output port parity (1 bit) = XOR reduction of q, combinational from registered q. After reset it equals ^RESET_VAL.
- Undefined: the parity port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package usr_pkg:
  - op enum typedef (usr_op_t, 3 bits) with the eight opcodes above.
  - State enum (usr_state_t: IDLE, SHIFT).
- Natural sub-module: usr_step, purely combinational. Inputs: q, op, si. Output: next q for one step. The top holds the FSM, counter and registers.

Test Plan (WIDTH=8, RESET_VAL=0):
1. LOAD, d=8'hA5 -> q=8'hA5 after one edge; done high 1 cycle; busy never high.
2. From 8'hA5, SHL amt=3 si=1 -> busy high 3 cycles; q passes 8'h4B, 8'h97, then 8'h2F; done pulses once.
3. From 8'h80, ASR amt=2 -> q=8'hE0. From 8'h3C, ROR amt=8 -> q=8'h3C after 8 busy cycles.
4. During an SHR amt=5, pulse start with LOAD d=8'hFF at the 2nd busy cycle -> ignored; SHR completes with the expected value; q!=8'hFF.
5. SHR amt=0 -> done pulse one cycle after start; q unchanged; busy stays 0. HOLD -> same response.
6. Assert reset between edges mid-ROL amt=6 -> q=8'h00, busy=0, done=0 immediately without a clock edge. After release, a LOAD works normally.
   - With USR_PARITY_EN, additionally check parity=1 for q=8'h07 and parity=0 for q=8'hA5.

Source files
------------

// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared types for the universal shift register
//
// Purpose: opcode and FSM state enums used by param_shift_register and usr_step,
// plus a helper that tells multi-step shift/rotate opcodes from single-cycle ones.
// Ports: none (package).

package usr_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_CLR  = 3'd2,
    OP_SHL  = 3'd3,
    OP_SHR  = 3'd4,
    OP_ASR  = 3'd5,
    OP_ROL  = 3'd6,
    OP_ROR  = 3'd7
  } usr_op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } usr_state_t;

  // Shift and rotate opcodes all sit at 3 and above.
  function automatic logic is_shift_op(input usr_op_t op);
    return (op >= OP_SHL);
  endfunction

endpackage

// File: rtl/usr_step.sv
// rtl/usr_step.sv - one single-bit shift/rotate step of the register contents
//
// Purpose: purely combinational next-value for one shift/rotate step.
// Ports:
//   q      in  WIDTH  current register contents
//   op     in  3      latched opcode (usr_op_t)
//   si     in  1      serial input bit (used by SHL/SHR only)
//   q_next out WIDTH  contents after one step; non-shift opcodes pass q through

import usr_pkg::*;

module usr_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  usr_op_t          op,
  input  logic             si,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (op)
      OP_SHL:  q_next = {q[WIDTH-2:0], si};
      OP_SHR:  q_next = {si, q[WIDTH-1:1]};
      OP_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      OP_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      OP_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/param_shift_register.sv
// rtl/param_shift_register.sv - parametrised universal storage/shift register
//
// Purpose: WIDTH-bit register driven by an op/amount command. HOLD/LOAD/CLR and
// zero-amount shifts complete in one cycle; shifts/rotates with amt>0 run one bit
// per clock while busy is high, then pulse done.
// Optional build macro: USR_PARITY_EN adds the parity output (XOR of q).
// Ports:
//   clk    in  1      system clock, rising edge
//   reset  in  1      asynchronous active-high reset
//   start  in  1      command strobe, only honoured while busy=0
//   op     in  3      opcode (usr_op_t)
//   amt    in  AMT_W  step count for shift/rotate opcodes
//   d      in  WIDTH  parallel load data
//   si     in  1      serial input, sampled on each shift step
//   q      out WIDTH  register contents
//   busy   out 1      multi-step shift in progress
//   done   out 1      one-cycle completion pulse
//   parity out 1      ^q (only with USR_PARITY_EN)

import usr_pkg::*;

module param_shift_register #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              AMT_W     = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] d,
  input  logic             si,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
`ifdef USR_PARITY_EN
  ,
  output logic             parity
`endif
);

  usr_state_t       state_q, state_d;
  usr_op_t          op_q, op_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_q;
  usr_op_t          op_in;

  assign op_in = usr_op_t'(op);

  usr_step #(.WIDTH(WIDTH)) u_step (
    .q      (data_q),
    .op     (op_q),
    .si     (si),
    .q_next (step_q)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!is_shift_op(op_in)) begin
            if (op_in == OP_LOAD) data_d = d;
            else if (op_in == OP_CLR) data_d = '0;
            done_d = 1'b1;
          end else if (amt == '0) begin
            done_d = 1'b1;
          end else begin
            // Only latch the command here; the first data step happens next edge.
            op_d    = op_in;
            cnt_d   = amt;
            busy_d  = 1'b1;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        data_d = step_q;
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_HOLD;
      cnt_q   <= '0;
      data_q  <= RESET_VAL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q    = data_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef USR_PARITY_EN
  assign parity = ^data_q;
`endif

endmodule
